bram_tx_backend: RTL and testbench

BRAM_TX_BACKEND -- requirements
Module: bram_tx_backend

---
 rtl/bram_tx_backend.sv | 224 ++++++++++++++++++++++
 tb/tb_bram_tx_backend.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_tx_backend.sv
// bram_tx_backend: streams a packet staged in BRAM (words 0..beats-1) out
// over an AXI-Stream master, one DATA_W word per beat.
// Flow: IDLE waits for start, RUN issues BRAM reads and drains a 2-entry
// skid FIFO, and DONE pulses finish for one cycle.
// BRAM read data arriving while the FIFO is empty is presented directly on the
// stream, so the first beat appears two cycles after start.
// Optional feature: define BRAM_TX_STATS_EN to add the pkt_count/byte_count
// statistics outputs.
module bram_tx_backend #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 6
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [15:0]           length_be,
  output logic                  finish,
`ifdef BRAM_TX_STATS_EN
  output logic [31:0]           pkt_count,
  output logic [31:0]           byte_count,
`endif
  output logic                  bram_enb,
  output logic [ADDR_W-1:0]     bram_addrb,
  input  logic [DATA_W-1:0]     bram_doutb,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready
);

  localparam int          BYTES     = DATA_W / 8;
  localparam int          KB        = $clog2(BYTES);
  localparam int          BEAT_W    = ADDR_W + 1;
  localparam int unsigned MAX_BYTES = BYTES << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q;
  logic [BEAT_W-1:0]   beats_q;
  logic [BEAT_W-1:0]   rd_idx_q;       // next word address to read
  logic [BYTES-1:0]    keep_last_q;
  logic                bram_enb_q;
  logic [ADDR_W-1:0]   bram_addrb_q;
  logic                enb_last_q;     // read issued this cycle is the final word
  logic                rvalid_q;       // BRAM data valid this cycle
  logic                rlast_q;        // ...and it is the final word
  logic                finish_q;

  // Skid FIFO: payload kept separately from control so it needs no reset.
  logic [DATA_W-1:0]   fifo_data_q [2];
  logic                fifo_last_q [2];
  logic                fifo_wr_q;
  logic                fifo_rd_q;
  logic [1:0]          fifo_cnt_q;
  logic [1:0]          fifo_cnt_d;

  // Start-time decode of the packet length.
  logic [15:0]         len_start;
  logic [BEAT_W-1:0]   beats_start;
  logic [KB-1:0]       rem_start;
  logic [BYTES-1:0]    keep_start;

  assign len_start   = (32'(length_be) > MAX_BYTES) ? 16'(MAX_BYTES) : length_be;
  assign beats_start = BEAT_W'((32'(len_start) + 32'(BYTES - 1)) >> KB);
  assign rem_start   = len_start[KB-1:0];

  // Last-beat byte mask: the low rem bytes, or every byte when rem is zero.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_keep
    assign keep_start[gi] = (rem_start == '0) || (KB'(gi) < rem_start);
  end

  // Output head: the FIFO front, or the BRAM word in flight when the FIFO is empty.
  logic                fifo_empty;
  logic                out_valid;
  logic [DATA_W-1:0]   head_data;
  logic                head_last;
  logic                xfer;
  logic                push;
  logic                pop;
  logic [2:0]          occ_next;
  logic                issue_ok;

  assign fifo_empty = (fifo_cnt_q == 2'd0);
  assign out_valid  = !fifo_empty || rvalid_q;
  assign head_data  = fifo_empty ? bram_doutb : fifo_data_q[fifo_rd_q];
  assign head_last  = fifo_empty ? rlast_q    : fifo_last_q[fifo_rd_q];
  assign xfer       = out_valid && m_axis_tready;
  assign pop        = xfer && !fifo_empty;
  assign push       = rvalid_q && !(fifo_empty && xfer);

  // FIFO occupancy after this edge.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + 2'd1;
    end else if (pop && !push) begin
      fifo_cnt_d = fifo_cnt_q - 2'd1;
    end
  end

  // A new read may issue only if its word, plus stored words and the read
  // already in flight, still fits in the two FIFO slots.
  assign occ_next = {1'b0, fifo_cnt_d} + {2'b00, bram_enb_q};
  assign issue_ok = (occ_next < 3'd2);

  // Control FSM, read issue and FIFO bookkeeping.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      beats_q      <= '0;
      rd_idx_q     <= '0;
      keep_last_q  <= '0;
      bram_enb_q   <= 1'b0;
      bram_addrb_q <= '0;
      enb_last_q   <= 1'b0;
      rvalid_q     <= 1'b0;
      rlast_q      <= 1'b0;
      finish_q     <= 1'b0;
      fifo_last_q  <= '{1'b0, 1'b0};
      fifo_wr_q    <= 1'b0;
      fifo_rd_q    <= 1'b0;
      fifo_cnt_q   <= 2'd0;
    end else begin
      rvalid_q   <= bram_enb_q;
      rlast_q    <= enb_last_q;
      fifo_cnt_q <= fifo_cnt_d;
      if (push) begin
        fifo_last_q[fifo_wr_q] <= rlast_q;
        fifo_wr_q              <= ~fifo_wr_q;
      end
      if (pop) begin
        fifo_rd_q <= ~fifo_rd_q;
      end

      finish_q   <= 1'b0;
      bram_enb_q <= 1'b0;
      enb_last_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            beats_q     <= beats_start;
            keep_last_q <= keep_start;
            state_q     <= S_RUN;
            if (beats_start != '0) begin
              bram_enb_q   <= 1'b1;
              bram_addrb_q <= '0;
              enb_last_q   <= (beats_start == BEAT_W'(1));
              rd_idx_q     <= BEAT_W'(1);
            end else begin
              rd_idx_q <= '0;
            end
          end
        end
        S_RUN: begin
          if (beats_q == '0) begin
            // Empty packet: nothing to send, just signal completion.
            state_q  <= S_DONE;
            finish_q <= 1'b1;
          end else if (xfer && head_last) begin
            state_q  <= S_DONE;
            finish_q <= 1'b1;
          end else if ((rd_idx_q < beats_q) && issue_ok) begin
            bram_enb_q   <= 1'b1;
            bram_addrb_q <= rd_idx_q[ADDR_W-1:0];
            enb_last_q   <= (rd_idx_q == beats_q - BEAT_W'(1));
            rd_idx_q     <= rd_idx_q + BEAT_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO payload storage.
  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_data_q[fifo_wr_q] <= bram_doutb;
    end
  end

  assign finish        = finish_q;
  assign bram_enb      = bram_enb_q;
  assign bram_addrb    = bram_addrb_q;
  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_valid ? head_data : '0;
  assign m_axis_tlast  = out_valid && head_last;
  assign m_axis_tkeep  = !out_valid ? '0 : (head_last ? keep_last_q : '1);

`ifdef BRAM_TX_STATS_EN
  logic [15:0] stat_len_q;
  logic [31:0] pkt_count_q;
  logic [31:0] byte_count_q;

  // Count completed packets and their (clamped) byte lengths.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      stat_len_q   <= '0;
      pkt_count_q  <= '0;
      byte_count_q <= '0;
    end else begin
      if ((state_q == S_IDLE) && start) begin
        stat_len_q <= len_start;
      end
      if (finish_q) begin
        pkt_count_q  <= pkt_count_q + 32'd1;
        byte_count_q <= byte_count_q + 32'(stat_len_q);
      end
    end
  end

  assign pkt_count  = pkt_count_q;
  assign byte_count = byte_count_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_bram_tx_backend.sv
// Testbench for bram_tx_backend: a BRAM model with registered read feeds the
// DUT; each packet's expected beats come from the BRAM contents and the
// length rules (clamp to 2048 bytes, 32 bytes per beat, remainder mask).
module tb_bram_tx_backend;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 6;
  localparam int BYTES  = DATA_W / 8;

  logic                aclk = 1'b0;
  logic                aresetn = 1'b0;
  logic                start = 1'b0;
  logic [15:0]         length_be = '0;
  logic                finish;
  logic                bram_enb;
  logic [ADDR_W-1:0]   bram_addrb;
  logic [DATA_W-1:0]   bram_doutb = '0;
  logic [DATA_W-1:0]   m_axis_tdata;
  logic [BYTES-1:0]    m_axis_tkeep;
  logic                m_axis_tvalid;
  logic                m_axis_tlast;
  logic                m_axis_tready = 1'b0;
`ifdef BRAM_TX_STATS_EN
  logic [31:0]         pkt_count;
  logic [31:0]         byte_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_pkt = 0;
  int exp_bytes = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  int addr_log[$];

  bram_tx_backend #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .start         (start),
    .length_be     (length_be),
    .finish        (finish),
`ifdef BRAM_TX_STATS_EN
    .pkt_count     (pkt_count),
    .byte_count    (byte_count),
`endif
    .bram_enb      (bram_enb),
    .bram_addrb    (bram_addrb),
    .bram_doutb    (bram_doutb),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  always #5 aclk = ~aclk;

  // BRAM port B model: one-cycle registered read, address log for ordering.
  always @(posedge aclk) begin
    if (bram_enb) begin
      bram_doutb <= mem[bram_addrb];
      addr_log.push_back(int'(bram_addrb));
    end
  end

  task automatic tick;
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_mem;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
  endtask

  function automatic logic [BYTES-1:0] exp_keep(input int k, input int nb, input int lc);
    logic [BYTES-1:0] one;
    one = 1;
    if (k == nb - 1 && (lc % BYTES) != 0) return (one << (lc % BYTES)) - one;
    return '1;
  endfunction

  // mode: 0 tready high, 1 tready toggling, 2 tready random.
  task automatic send_pkt(input int len_be, input int mode, input int abort_at,
                          input bit start_in_run, input bit start_at_finish);
    int lc, nb, k, first_v, last_c, fin_c, fin_n, s_cyc;
    bit prev_v, prev_r, done;
    logic [DATA_W-1:0] prev_d;
    logic [BYTES-1:0]  prev_k;
    logic              prev_l;
    lc = (len_be > BYTES * (1 << ADDR_W)) ? BYTES * (1 << ADDR_W) : len_be;
    nb = (lc + BYTES - 1) / BYTES;
    k = 0; first_v = -1; last_c = -1; fin_c = -1; fin_n = 0;
    prev_v = 0; prev_r = 0; done = 0;
    prev_d = '0; prev_k = '0; prev_l = 1'b0;
    addr_log.delete();
    start = 1'b1;
    length_be = 16'(len_be);
    s_cyc = cyc;
    tick;
    for (int t = 0; t < 600 && !done; t++) begin
      start = 1'b0;
      if (start_in_run && cyc == s_cyc + 1) begin
        start = 1'b1;
        length_be = 16'd96;
      end
      case (mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (cyc % 2 == 0);
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      if (abort_at >= 0 && m_axis_tvalid && k == abort_at) begin
        aresetn = 1'b0;
        tick;
        chk("abort_tvalid", m_axis_tvalid, 0);
        chk("abort_finish", finish, 0);
        chk("abort_enb", bram_enb, 0);
        chk("abort_addr", bram_addrb, 0);
        aresetn = 1'b1;
        exp_pkt = 0;
        exp_bytes = 0;
        repeat (6) begin
          tick;
          chk("post_abort_tvalid", m_axis_tvalid, 0);
          chk("post_abort_finish", finish, 0);
        end
        $display("pkt len=%0d aborted at beat %0d", len_be, k);
        return;
      end
      if (prev_v && !prev_r) begin
        chk("hold_tvalid", m_axis_tvalid, 1);
        chk("hold_tdata", m_axis_tdata, prev_d);
        chk("hold_tkeep", m_axis_tkeep, prev_k);
        chk("hold_tlast", m_axis_tlast, prev_l);
      end
      if (m_axis_tvalid && first_v < 0) first_v = cyc;
      if (k >= nb) begin
        chk("extra_beat", m_axis_tvalid, 0);
      end else if (m_axis_tvalid && m_axis_tready) begin
        chk("beat_tdata", m_axis_tdata, mem[k]);
        chk("beat_tkeep", m_axis_tkeep, exp_keep(k, nb, lc));
        chk("beat_tlast", m_axis_tlast, (k == nb - 1));
        if (k == nb - 1) last_c = cyc;
        k++;
      end
      if (finish) begin
        fin_n++;
        if (fin_c < 0) fin_c = cyc;
        if (start_at_finish) begin
          start = 1'b1;
          length_be = 16'd64;
        end
      end
      if (fin_c >= 0 && cyc >= fin_c + 4) done = 1;
      prev_v = m_axis_tvalid; prev_r = m_axis_tready;
      prev_d = m_axis_tdata;  prev_k = m_axis_tkeep; prev_l = m_axis_tlast;
      tick;
    end
    start = 1'b0;
    chk("timeout", done, 1);
    chk("beat_count", k, nb);
    chk("finish_count", fin_n, 1);
    chk("finish_cycle", fin_c, (nb > 0) ? last_c + 1 : s_cyc + 2);
    if (nb > 0) chk("first_valid_cycle", first_v, s_cyc + 2);
    if (mode == 0 && nb > 0) chk("last_beat_cycle", last_c, s_cyc + 1 + nb);
    chk("read_count", addr_log.size(), nb);
    for (int i = 0; i < addr_log.size() && i < nb; i++) begin
      chk("read_addr", addr_log[i], i);
    end
    exp_pkt += 1;
    exp_bytes += lc;
    $display("pkt len=%0d mode=%0d beats=%0d sent=%0d finish@+%0d", len_be, mode, nb, k, fin_c - s_cyc);
  endtask

  initial begin
    fill_mem;
    aresetn = 1'b0;
    repeat (3) tick;
    chk("rst_finish", finish, 0);
    chk("rst_enb", bram_enb, 0);
    chk("rst_addr", bram_addrb, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tkeep", m_axis_tkeep, 0);
    chk("rst_tdata", m_axis_tdata, 0);
`ifdef BRAM_TX_STATS_EN
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_byte_count", byte_count, 0);
`endif
    $display("reset state checked");
    aresetn = 1'b1;
    tick;

    send_pkt(60, 0, -1, 0, 0);
    send_pkt(1514, 0, -1, 1, 0);
`ifdef BRAM_TX_STATS_EN
    chk("stats_pkt_count", pkt_count, 2);
    chk("stats_byte_count", byte_count, 1574);
`endif
    fill_mem;
    send_pkt(64, 1, -1, 0, 1);
    send_pkt(0, 0, -1, 1, 0);
    send_pkt(1514, 0, 10, 0, 0);
    send_pkt(60, 0, -1, 0, 0);
    fill_mem;
    send_pkt(3000, 2, -1, 0, 0);
    for (int p = 0; p < 6; p++) begin
      fill_mem;
      send_pkt(int'($urandom_range(0, 2100)), 2, -1, 0, 0);
    end
`ifdef BRAM_TX_STATS_EN
    chk("final_pkt_count", pkt_count, exp_pkt);
    chk("final_byte_count", byte_count, exp_bytes);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
